// File: rtl/riscv_prefetch_buffer_mo.sv
// Instruction prefetch buffer: pipelined gnt/rvalid fetch into a small FIFO,
// with stale responses after a branch dropped through a discard counter.
module riscv_prefetch_buffer_mo #(
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  input  logic                  branch_i,
  input  logic [ADDR_WIDTH-1:0] branch_addr_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  instr_req_o,
  input  logic                  instr_gnt_i,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  input  logic [DATA_WIDTH-1:0] instr_rdata_i,
  input  logic                  instr_rvalid_i,
  output logic                  busy_o
);
  localparam int STEP = DATA_WIDTH / 8;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(FIFO_DEPTH) + 2;

  localparam logic [CW-1:0]         DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]         MAX_OUT_C  = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0]         ONE_C      = CW'(1);
  localparam logic [PW-1:0]         PTR_ONE    = PW'(1);
  localparam logic [ADDR_WIDTH-1:0] STEP_C     = ADDR_WIDTH'(STEP);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(STEP - 1));

  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic [ADDR_WIDTH-1:0] rsp_addr;
  logic [ADDR_WIDTH-1:0] branch_target;
  logic [CW-1:0]         outst_cnt;
  logic [CW-1:0]         discard_cnt;
  logic [CW-1:0]         fifo_cnt;
  logic [CW-1:0]         live;
  logic [CW-1:0]         rsp_dec;
  logic                  pending_q;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
  logic                  grant;
  logic                  rsp_ok;
  logic                  drop;
  logic                  push;
  logic                  pop;
  logic                  credit_ok;
  logic                  slot_ok;

  assign branch_target = branch_addr_i & ALIGN_MASK;
  assign live          = outst_cnt - discard_cnt;
  // Credit counts buffered words plus live in-flight words, so a push never overflows.
  assign credit_ok     = (fifo_cnt + live) < DEPTH_C;
  assign slot_ok       = outst_cnt < MAX_OUT_C;

  assign instr_req_o   = pending_q | (req_i & slot_ok & (branch_i | credit_ok));
  assign instr_addr_o  = branch_i ? branch_target : fetch_addr;
  assign grant         = instr_req_o & instr_gnt_i;

  assign rsp_ok        = instr_rvalid_i & (outst_cnt != '0);
  assign rsp_dec       = {{(CW-1){1'b0}}, rsp_ok};
  assign drop          = rsp_ok & (discard_cnt != '0);
  assign push          = rsp_ok & ~drop & ~branch_i;

  assign valid_o       = (fifo_cnt != '0) & ~branch_i;
  assign pop           = valid_o & ready_i;
  assign rdata_o       = mem_data[rd_ptr];
  assign addr_o        = mem_addr[rd_ptr];
  assign busy_o        = (outst_cnt != '0) | instr_req_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_addr  <= '0;
      rsp_addr    <= '0;
      outst_cnt   <= '0;
      discard_cnt <= '0;
      pending_q   <= 1'b0;
    end else begin
      pending_q <= instr_req_o & ~instr_gnt_i;

      if (grant)         fetch_addr <= instr_addr_o + STEP_C;
      else if (branch_i) fetch_addr <= branch_target;

      case ({grant, rsp_ok})
        2'b10:   outst_cnt <= outst_cnt + ONE_C;
        2'b01:   outst_cnt <= outst_cnt - ONE_C;
        default: outst_cnt <= outst_cnt;
      endcase

      // A grant in the branch cycle belongs to the new target, so only older requests are discarded.
      if (branch_i)  discard_cnt <= outst_cnt - rsp_dec;
      else if (drop) discard_cnt <= discard_cnt - ONE_C;

      if (branch_i)  rsp_addr <= branch_target;
      else if (push) rsp_addr <= rsp_addr + STEP_C;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_addr[i] <= '0;
      end
    end else if (branch_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= instr_rdata_i;
        mem_addr[wr_ptr] <= rsp_addr;
        wr_ptr           <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + ONE_C;
        2'b01:   fifo_cnt <= fifo_cnt - ONE_C;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  a_no_spurious_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
    !(instr_rvalid_i && outst_cnt == '0))
    else $error("rvalid received with no outstanding request");

endmodule

// File: doc/riscv_prefetch_buffer_mo.md
Name: riscv_prefetch_buffer_mo

Overview:
Next-generation instruction prefetch buffer for the RISCY fetch stage. It supports a configurable FIFO depth and fetch width, and keeps up to MAX_OUTSTANDING pipelined memory transactions in flight. In-flight responses made stale by a branch are dropped using a discard counter. It sits between the IF stage (req/branch/ready) and the instruction memory or I-cache, using the gnt/rvalid protocol. Hardware-loop and unaligned-compressed handling are out of scope; the IF stage realigns.

Parameters:
FIFO_DEPTH, 4, number of fetched words buffered; power of 2, >= 2.
MAX_OUTSTANDING, 2, maximum granted-but-unanswered requests; 1..FIFO_DEPTH.
ADDR_WIDTH, 32, address width.
DATA_WIDTH, 32, fetch word width; 32 or 64. Address stride STEP = DATA_WIDTH/8.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_i  in  1  IF stage wants instructions; prefetch enable.
branch_i  in  1  redirect fetch to branch_addr_i; single-cycle pulse.
branch_addr_i  in  ADDR_WIDTH  branch target; low log2(STEP) bits ignored.
ready_i  in  1  IF stage consumes head entry when valid_o is high.
valid_o  out  1  head entry valid.
rdata_o  out  DATA_WIDTH  head entry data.
addr_o  out  ADDR_WIDTH  aligned address of head entry.
instr_req_o  out  1  memory request.
instr_gnt_i  in  1  memory grant.
instr_addr_o  out  ADDR_WIDTH  request address, always STEP-aligned.
instr_rdata_i  in  DATA_WIDTH  response data.
instr_rvalid_i  in  1  response valid; responses return in order.
busy_o  out  1  outstanding transactions exist or a request is pending.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All outputs 0. FIFO empty.
  - Registers cleared: fetch_addr, rsp_addr, outst_cnt, discard_cnt.
- Counters:
  - outst_cnt: +1 on instr_req_o & instr_gnt_i; -1 on instr_rvalid_i; both in one cycle means no change.
  - live = outst_cnt - discard_cnt.
- Issue rule: instr_req_o = req_i & (outst_cnt < MAX_OUTSTANDING) & (fifo_cnt + live < FIFO_DEPTH), or pending_q.
  - The credit rule guarantees no FIFO overflow.
  - The cycle of branch_i ignores the credit term but still honours MAX_OUTSTANDING.
- Request stability:
  - Once instr_req_o=1 without grant, pending_q is set, and req and addr are held until gnt.
  - Exception: branch_i replaces the held address with the branch target.
  - Deasserting req_i does not withdraw a pending request.
- Address: instr_addr_o = branch_i ? aligned(branch_addr_i) : fetch_addr.
  - On grant, fetch_addr <= instr_addr_o + STEP.
  - On branch without grant, fetch_addr <= aligned target.
  - Addition wraps modulo 2^ADDR_WIDTH.
- Branch, same cycle:
  - FIFO cleared; valid_o forced 0.
  - discard_cnt <= outst_cnt - instr_rvalid_i. A request granted in the branch cycle is the new target's request and is not discarded.
  - rsp_addr <= aligned target.
  - A back-to-back branch accumulates: discard_cnt <= discard_cnt + live pending, never exceeding outst_cnt.
- Response:
  - On rvalid with discard_cnt>0: drop the response, discard_cnt -1.
  - Otherwise push {rsp_addr, instr_rdata_i} into the FIFO and set rsp_addr += STEP.
  - No bypass: data appears on valid_o the cycle after rvalid.
- Output: valid_o = fifo not empty & ~branch_i; pop on valid_o & ready_i.
  - Push and pop in the same cycle are allowed when full or empty-after-push.
- busy_o = (outst_cnt != 0) | instr_req_o.
- Protocol error: rvalid with outst_cnt==0 is ignored, and a simulation assertion fires.
- Reset mid-transaction: all state is dropped. The memory side is reset by the same rst_n.

Test Plan:
- Sequential fetch: branch to 0x100, req_i=1, gnt always 1, rvalid one cycle later, ready_i=1 → instr_addr_o sequence 0x100, 0x104, 0x108…; addr_o sequence identical, one word per cycle after 3-cycle fill.
- Backpressure: ready_i=0, FIFO_DEPTH=4, MAX_OUTSTANDING=2 → exactly 4 grants, then instr_req_o=0 while fifo_cnt=4. Raise ready_i → fetch resumes at 0x110.
- Branch with 2 in flight: outstanding to 0x200 and 0x204, branch_i to 0x80 with gnt=1 → discard_cnt=2. Next 2 rvalids dropped; the 3rd rvalid is pushed with addr_o=0x80. No 0x200/0x204 data ever reaches valid_o.
- Grant stall: gnt=0 for 5 cycles → instr_req_o and instr_addr_o=0x300 stable. A branch to 0x40 in cycle 3 switches the address to 0x40, which is held until gnt.
- Branch coincident with rvalid: outst_cnt=1, rvalid and branch_i in the same cycle → the response is dropped, discard_cnt=0, and the FIFO is empty next cycle.
- Async reset during WAIT (outst_cnt=2): after rst_n release, valid_o=0, busy_o=0, instr_req_o=0. Stale rvalids trigger the assertion and are not pushed.
